// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the PC, issues word reads to a
// synchronous instruction memory (data returns one cycle after the request),
// buffers returned instructions in a small FIFO and presents the head entry to
// decode. Redirects flush the buffer and kill the outstanding read.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushed /
// perf_stall event counters.
module fetch_stage #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IMEM_AW    = 10,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_inst,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Handshake towards decode: an entry transfers on a cycle where if_valid
    // and id_ready are both high and no redirect is present; if_* stay stable
    // while if_valid is high and id_ready is low.

    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [XLEN-1:0] buf_inst [FIFO_DEPTH];
    logic [XLEN-1:0] buf_pc   [FIFO_DEPTH];

    logic            pop;
    logic            wr;
    logic            issue;
    logic [CW:0]     occ;
    logic [CW:0]     limit;

    // A read returning this cycle lands in the FIFO unless a redirect kills it.
    assign wr    = inflight & ~redirect_valid;
    assign pop   = if_valid & id_ready & ~redirect_valid;

    // Issue only while buffered + outstanding entries still fit after this
    // cycle's pop; compared as occ < DEPTH + pop to avoid an underflowing subtract.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign limit = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
    assign issue = ~redirect_valid & (occ < limit);

    // The strobe is forced low while reset is held so no read starts mid-reset.
    assign imem_req  = issue & ~RST;
    assign imem_addr = pc[IMEM_AW+1:2];

    assign if_valid    = (count != '0);
    assign if_inst     = if_valid ? buf_inst[head] : '0;
    assign if_pc       = if_valid ? buf_pc[head] : '0;
    assign if_pc_plus4 = if_valid ? buf_pc[head] + XLEN'(4) : '0;

    // PC, in-flight tracker and FIFO pointers; redirect overrides everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc & ~XLEN'(3);
            inflight    <= 1'b0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (issue) begin
                pc          <= pc + XLEN'(4);
                inflight_pc <= pc;
            end
            inflight <= issue;
            if (wr) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(wr) - CW'(pop);
        end
    end

    // FIFO storage: capture the returning word together with the PC it was fetched from.
    always_ff @(posedge CLK) begin
        if (wr) begin
            buf_inst[tail] <= imem_rdata;
            buf_pc[tail]   <= inflight_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters: delivered instructions, work discarded by redirects, decode stall cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed <= perf_flushed + 32'(count) + 32'(inflight);
            end
            if (if_valid & ~id_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. A queue-based model tracks
// which PCs must be buffered, a compare process checks every cycle against it,
// and directed checks pin latency, stall, redirect, wrap and reset behaviour.
module tb_fetch_stage;

    localparam int XLEN    = 32;
    localparam int IMEM_AW = 10;
    localparam int DEPTH   = 2;

    logic               CLK;
    logic               RST;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [XLEN-1:0]    imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               id_ready;
    logic               if_valid;
    logic [XLEN-1:0]    if_inst;
    logic [XLEN-1:0]    if_pc;
    logic [XLEN-1:0]    if_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_flushed;
    logic [31:0]        perf_stall;
    logic [31:0]        m_fetched;
    logic [31:0]        m_flushed;
    logic [31:0]        m_stall;
`endif

    fetch_stage #(
        .XLEN(XLEN), .RESET_PC(32'h0000_0000), .IMEM_AW(IMEM_AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory contents: word at index a is 0x1000_0000 | a.
    function automatic logic [31:0] word(input logic [IMEM_AW-1:0] a);
        return 32'h1000_0000 | {22'd0, a};
    endfunction

    // Synchronous instruction memory; garbage on non-request cycles.
    always @(posedge CLK) begin
        imem_rdata <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] exp_q[$];   // PCs that must be sitting in the buffer, oldest first
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    bit          m_pop;
    bit          m_iss;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q.delete();
            m_infl    = 1'b0;
            m_infl_pc = 32'd0;
            m_pc      = 32'd0;
`ifdef FETCH_PERF_EN
            m_fetched = 0; m_flushed = 0; m_stall = 0;
`endif
        end else begin
            m_pop = (exp_q.size() != 0) && id_ready && !redirect_valid;
            m_iss = !redirect_valid &&
                    (exp_q.size() + int'(m_infl) - int'(m_pop) < DEPTH);
`ifdef FETCH_PERF_EN
            if (m_pop) m_fetched = m_fetched + 1;
            if (exp_q.size() != 0 && !id_ready) m_stall = m_stall + 1;
            if (redirect_valid) m_flushed = m_flushed + exp_q.size() + int'(m_infl);
`endif
            if (redirect_valid) begin
                exp_q.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_infl) exp_q.push_back(m_infl_pc);
                m_infl = m_iss;
                if (m_iss) begin
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_pop;
    logic        e_req;

    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_if_valid", if_valid, 0);
            chk("rst_if_pc", if_pc, 0);
            chk("rst_if_inst", if_inst, 0);
            chk("rst_if_pc_plus4", if_pc_plus4, 0);
            chk("rst_imem_req", imem_req, 0);
        end else begin
            e_valid = (exp_q.size() != 0);
            e_pc    = 32'd0;
            if (e_valid) e_pc = exp_q[0];
            e_pop = e_valid && id_ready && !redirect_valid;
            e_req = !redirect_valid && (exp_q.size() + int'(m_infl) - int'(e_pop) < DEPTH);
            chk("cyc_if_valid", if_valid, e_valid);
            chk("cyc_if_pc", if_pc, e_pc);
            chk("cyc_if_inst", if_inst, e_valid ? word(e_pc[IMEM_AW+1:2]) : 32'd0);
            chk("cyc_if_pc_plus4", if_pc_plus4, e_valid ? e_pc + 32'd4 : 32'd0);
            chk("cyc_imem_req", imem_req, e_req);
            if (e_req) chk("cyc_imem_addr", imem_addr, m_pc[IMEM_AW+1:2]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] pat;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        pat = 16'b1011_0011_1110_0101;
        repeat (2) tick();
        #2;
        chk("reset_if_valid", if_valid, 0);
        chk("reset_imem_req", imem_req, 0);

        // Reset release: one issue per cycle, first if_valid at cycle 2.
        tick(); RST = 1'b0; #2;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 0);
        tick(); #2;
        chk("c1_addr", imem_addr, 1);
        chk("c1_if_valid", if_valid, 0);
        tick(); #2;
        chk("c2_if_valid", if_valid, 1);
        chk("c2_if_pc", if_pc, 32'h0);
        chk("c2_if_pc_plus4", if_pc_plus4, 32'h4);
        chk("c2_if_inst", if_inst, 32'h1000_0000);
        tick(); #2;
        chk("c3_if_pc", if_pc, 32'h4);

        // Decode stall for 5 cycles at pc 8.
        tick(); id_ready = 1'b0; #2;
        chk("stall_if_pc", if_pc, 32'h8);
        chk("stall_req_drop", imem_req, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #2;
            chk("stall_hold_pc", if_pc, 32'h8);
            chk("stall_hold_inst", if_inst, 32'h1000_0002);
            chk("stall_hold_req", imem_req, 0);
        end
        tick(); id_ready = 1'b1; #2;
        chk("release_pc0", if_pc, 32'h8);
        tick(); #2;
        chk("release_pc1", if_pc, 32'hC);
        tick(); #2;
        chk("release_pc2", if_pc, 32'h10);

        // Fill the buffer, then redirect to 0x40.
        tick(); id_ready = 1'b0;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #2;
        chk("full_if_valid", if_valid, 1);
        chk("redir_no_req", imem_req, 0);
        tick(); redirect_valid = 1'b0; id_ready = 1'b1; #2;
        chk("redir_flush_valid", if_valid, 0);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h10);
        tick(); #2;
        chk("redir_gap_valid", if_valid, 0);
        tick(); #2;
        chk("redir_first_valid", if_valid, 1);
        chk("redir_first_pc", if_pc, 32'h40);
        chk("redir_first_inst", if_inst, 32'h1000_0010);

        // Misaligned redirect target.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(); redirect_valid = 1'b0; #2;
        chk("align_addr", imem_addr, 32'h40);
        tick(); tick(); #2;
        chk("align_pc", if_pc, 32'h100);
        chk("align_pc_plus4", if_pc_plus4, 32'h104);

        // Back-to-back redirects: the last one wins.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); redirect_pc = 32'h302;
        tick(); redirect_valid = 1'b0; #2;
        chk("last_redir_addr", imem_addr, 32'hC0);
        tick(); tick(); #2;
        chk("last_redir_pc", if_pc, 32'h300);

        // PC wrap at 2^32.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick(); redirect_valid = 1'b0; #2;
        chk("wrap_addr", imem_addr, 32'h3FE);
        tick(); tick(); #2;
        chk("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        tick(); #2;
        chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", if_pc_plus4, 32'h0);
        tick(); #2;
        chk("wrap_pc2", if_pc, 32'h0);
        chk("wrap_inst2", if_inst, 32'h1000_0000);

        // Irregular decode readiness; the per-cycle compare covers this stretch.
        for (int i = 0; i < 16; i++) begin
            tick(); id_ready = pat[i];
        end
        id_ready = 1'b1;
        repeat (3) tick();

        // Reset pulse mid-stream: outputs clear at once, stale return dropped.
        RST = 1'b1; #1;
        chk("midrst_if_valid", if_valid, 0);
        chk("midrst_if_pc", if_pc, 0);
        chk("midrst_if_inst", if_inst, 0);
        chk("midrst_req", imem_req, 0);
        #1; RST = 1'b0; #1;
        chk("postrst_req", imem_req, 1);
        chk("postrst_addr", imem_addr, 0);
        tick(); #2;
        chk("postrst_stale_dropped", if_valid, 0);
        tick(); #2;
        chk("postrst_valid", if_valid, 1);
        chk("postrst_pc", if_pc, 32'h0);
        chk("postrst_inst", if_inst, 32'h1000_0000);

`ifdef FETCH_PERF_EN
        // Three pops then a stall and a redirect, from the post-reset state.
        repeat (3) tick();
        id_ready = 1'b0;
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick(); redirect_valid = 1'b0; id_ready = 1'b1; #2;
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stall);
        chk("perf_flushed", perf_flushed, m_flushed);
        chk("perf_flushed_lit", perf_flushed, 32'd2);
`endif

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
